// File: rtl/barrel_seq.sv
// barrel_seq: command sequencer for a registered rotate-right barrel stage.
// Loads a word into the barrel, steps it a programmed number of times,
// captures the barrel output, compares it against an internally computed
// rotation and hands the result back over a valid/ready interface.
module barrel_seq #(
    parameter int DATA_W  = 8,
    parameter int SEL_W   = 3,
    parameter int STEP_W  = 4,
    parameter int BRL_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [SEL_W-1:0]  cmd_amt,
    input  logic [STEP_W-1:0] cmd_steps,
    output logic              brl_load,
    output logic [SEL_W-1:0]  brl_sel,
    output logic [DATA_W-1:0] brl_din,
    input  logic [DATA_W-1:0] brl_dout,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [DATA_W-1:0] res_expected,
    output logic              err_flag,
    output logic [7:0]        err_cnt,
    output logic              busy
);

    localparam int TOT_W = SEL_W + STEP_W;
    localparam int LAT_W = 3;

    typedef enum logic [1:0] {IDLE, ROT, CAP, DONE} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [SEL_W-1:0]    amt_q, amt_d;
    logic [STEP_W-1:0]   steps_q, steps_d;
    logic [STEP_W-1:0]   cnt_q, cnt_d;
    logic                first_q, first_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [DATA_W-1:0]   res_data_q, res_data_d;
    logic [DATA_W-1:0]   res_exp_q, res_exp_d;
    logic                err_flag_q, err_flag_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic [SEL_W-1:0]    rot_total;
    logic [DATA_W-1:0]   exp_val;

    // Rotate right by n; DATA_W is a power of two so n covers every amount.
    function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x,
                                               input logic [SEL_W-1:0]  n);
        logic [2*DATA_W-1:0] dbl;
        dbl = {x, x} >> n;
        return dbl[DATA_W-1:0];
    endfunction

    // Total rotation is amt*steps modulo DATA_W, i.e. the low SEL_W bits of the product.
    always_comb begin
        rot_total = SEL_W'(TOT_W'(amt_q) * TOT_W'(steps_q));
        exp_val   = rotr(data_q, rot_total);
    end

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            data_q     <= '0;
            amt_q      <= '0;
            steps_q    <= '0;
            cnt_q      <= '0;
            first_q    <= 1'b0;
            lat_q      <= '0;
            res_data_q <= '0;
            res_exp_q  <= '0;
            err_flag_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            amt_q      <= amt_d;
            steps_q    <= steps_d;
            cnt_q      <= cnt_d;
            first_q    <= first_d;
            lat_q      <= lat_d;
            res_data_q <= res_data_d;
            res_exp_q  <= res_exp_d;
            err_flag_q <= err_flag_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Next-state logic: command latch, step/latency counting, result capture.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        amt_d      = amt_q;
        steps_d    = steps_q;
        cnt_d      = cnt_q;
        first_d    = first_q;
        lat_d      = lat_q;
        res_data_d = res_data_q;
        res_exp_d  = res_exp_q;
        err_flag_d = 1'b0;
        err_cnt_d  = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = ROT;
                    data_d  = cmd_data;
                    first_d = 1'b1;
                    if (cmd_steps == '0) begin
                        // Pass-through: a single load cycle with no rotation.
                        amt_d   = '0;
                        steps_d = STEP_W'(1);
                        cnt_d   = '0;
                    end else begin
                        amt_d   = cmd_amt;
                        steps_d = cmd_steps;
                        cnt_d   = cmd_steps - STEP_W'(1);
                    end
                end
            end
            ROT: begin
                first_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d = CAP;
                    lat_d   = LAT_W'(BRL_LAT - 1);
                end else begin
                    cnt_d = cnt_q - STEP_W'(1);
                end
            end
            CAP: begin
                if (lat_q == '0) begin
                    state_d    = DONE;
                    res_data_d = brl_dout;
                    res_exp_d  = exp_val;
                    if (brl_dout != exp_val) begin
                        err_flag_d = 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                    end
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: barrel drive is only active while rotating.
    always_comb begin
        cmd_ready    = (state_q == IDLE);
        busy         = (state_q != IDLE);
        res_valid    = (state_q == DONE);
        brl_load     = 1'b0;
        brl_sel      = '0;
        brl_din      = data_q;
        res_data     = res_data_q;
        res_expected = res_exp_q;
        err_flag     = err_flag_q;
        err_cnt      = err_cnt_q;
        if (state_q == ROT) begin
            brl_load = first_q;
            brl_sel  = amt_q;
        end
    end

endmodule

// File: tb/tb_barrel_seq.sv
// Testbench for barrel_seq: behavioural barrel model plus a reference model
// that rotates one bit at a time to predict each result.
module tb_barrel_seq;

    localparam int DATA_W  = 8;
    localparam int SEL_W   = 3;
    localparam int STEP_W  = 4;
    localparam int BRL_LAT = 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_data = '0;
    logic [SEL_W-1:0]  cmd_amt = '0;
    logic [STEP_W-1:0] cmd_steps = '0;
    logic              brl_load;
    logic [SEL_W-1:0]  brl_sel;
    logic [DATA_W-1:0] brl_din;
    logic [DATA_W-1:0] brl_dout;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [DATA_W-1:0] res_data;
    logic [DATA_W-1:0] res_expected;
    logic              err_flag;
    logic [7:0]        err_cnt;
    logic              busy;

    int  checks = 0;
    int  errors = 0;
    int  err_model = 0;
    bit  flip = 1'b0;
    bit  offer_next = 1'b0;
    logic [7:0] nxt_data;
    logic [2:0] nxt_amt;
    logic [3:0] nxt_steps;

    always #5 clk = ~clk;

    barrel_seq #(
        .DATA_W(DATA_W), .SEL_W(SEL_W), .STEP_W(STEP_W), .BRL_LAT(BRL_LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .cmd_amt(cmd_amt), .cmd_steps(cmd_steps),
        .brl_load(brl_load), .brl_sel(brl_sel), .brl_din(brl_din),
        .brl_dout(brl_dout),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_expected(res_expected),
        .err_flag(err_flag), .err_cnt(err_cnt), .busy(busy)
    );

    // Barrel rotate using plain shifts on an int.
    function automatic logic [7:0] brl_rot(input logic [7:0] x, input int n);
        int v;
        v = int'(x);
        return 8'((v >> n) | (v << (8 - n)));
    endfunction

    // Registered barrel; optional fault flips bit 0 of every registered value.
    always @(posedge clk) begin
        if (reset) brl_dout <= '0;
        else brl_dout <= brl_rot(brl_load ? brl_din : brl_dout, int'(brl_sel)) ^ {7'b0, flip};
    end

    // Reference: rotate right one bit per unit of total rotation.
    function automatic logic [7:0] model_rot(input logic [7:0] d, input int amt, input int eff);
        logic [7:0] r;
        r = d;
        for (int i = 0; i < amt * eff; i++) r = {r[0], r[7:1]};
        return r;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One command through to its result handshake; called at a negedge, returns at a negedge.
    task automatic run_cmd(input logic [7:0] d, input logic [2:0] a, input logic [3:0] s,
                           input int hold, input bit flip_en);
        logic [7:0] exp_v, res_v, first_res;
        int eff, k, busy_n, w, eff_amt;
        eff     = (s == 0) ? 1 : int'(s);
        eff_amt = (s == 0) ? 0 : int'(a);
        exp_v   = model_rot(d, eff_amt, eff);
        res_v   = flip_en ? (exp_v ^ 8'h01) : exp_v;
        flip    = flip_en;
        cmd_valid = 1'b1; cmd_data = d; cmd_amt = a; cmd_steps = s;
        w = 0;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check_val("cmd_ready_offer", cmd_ready, 1);
        res_ready = (hold == 0);
        k = 0;
        busy_n = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) cmd_valid = 1'b0;
            if (busy) busy_n++;
            if (k <= eff) begin
                check_val("brl_load", brl_load, (k == 1) ? 1 : 0);
                check_val("brl_sel", brl_sel, eff_amt);
                check_val("brl_din", brl_din, d);
                check_val("cmd_ready_busy", cmd_ready, 0);
            end
            if (!res_valid) check_val("err_flag_idle", err_flag, 0);
        end while (!res_valid && k < 40);
        check_val("latency", k, eff + BRL_LAT + 1);
        if (res_v != exp_v && err_model < 255) err_model++;
        check_val("res_data", res_data, res_v);
        check_val("res_expected", res_expected, exp_v);
        check_val("err_flag_done", err_flag, (res_v != exp_v) ? 1 : 0);
        check_val("err_cnt", err_cnt, err_model);
        first_res = res_data;
        if (offer_next) begin
            cmd_valid = 1'b1; cmd_data = nxt_data; cmd_amt = nxt_amt; cmd_steps = nxt_steps;
        end
        for (int h = 1; h <= hold; h++) begin
            @(negedge clk);
            if (busy) busy_n++;
            check_val("hold_valid", res_valid, 1);
            check_val("hold_data", res_data, first_res);
            check_val("hold_cmd_ready", cmd_ready, 0);
            check_val("hold_err_flag", err_flag, 0);
            if (h == hold) res_ready = 1'b1;
        end
        @(negedge clk);
        res_ready = 1'b0;
        check_val("post_valid", res_valid, 0);
        check_val("post_cmd_ready", cmd_ready, 1);
        check_val("post_err_flag", err_flag, 0);
        check_val("busy_cycles", busy_n, eff + BRL_LAT + 1 + hold);
        $display("cmd data=%02h amt=%0d steps=%0d hold=%0d -> res=%02h exp=%02h err_cnt=%0d",
                 d, a, s, hold, first_res, exp_v, err_cnt);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        // Reset state
        check_val("rst_cmd_ready", cmd_ready, 1);
        check_val("rst_brl_load", brl_load, 0);
        check_val("rst_brl_sel", brl_sel, 0);
        check_val("rst_brl_din", brl_din, 0);
        check_val("rst_res_valid", res_valid, 0);
        check_val("rst_res_data", res_data, 0);
        check_val("rst_res_expected", res_expected, 0);
        check_val("rst_err_flag", err_flag, 0);
        check_val("rst_err_cnt", err_cnt, 0);
        check_val("rst_busy", busy, 0);

        // Directed cases
        run_cmd(8'h96, 3'd3, 4'd2, 0, 1'b0);
        run_cmd(8'hA5, 3'd1, 4'd8, 0, 1'b0);
        run_cmd(8'h3C, 3'd5, 4'd0, 0, 1'b0);
        run_cmd(8'h01, 3'd1, 4'd1, 0, 1'b1);

        // Held result with a command waiting
        offer_next = 1'b1;
        nxt_data = 8'h11; nxt_amt = 3'd2; nxt_steps = 4'd1;
        run_cmd(8'hC3, 3'd7, 4'd3, 5, 1'b0);
        offer_next = 1'b0;
        run_cmd(nxt_data, nxt_amt, nxt_steps, 0, 1'b0);

        // Randomized commands
        for (int i = 0; i < 24; i++) begin
            run_cmd(8'($urandom), 3'($urandom), 4'($urandom_range(0, 15)),
                    int'($urandom_range(0, 2)), 1'b0);
        end

        // Reset during ROT step 2 of a 4-step command
        cmd_valid = 1'b1; cmd_data = 8'h5F; cmd_amt = 3'd2; cmd_steps = 4'd4;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check_val("mid_busy", busy, 1);
        check_val("mid_brl_load", brl_load, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        err_model = 0;
        check_val("mr_busy", busy, 0);
        check_val("mr_brl_load", brl_load, 0);
        check_val("mr_res_valid", res_valid, 0);
        check_val("mr_err_cnt", err_cnt, 0);
        check_val("mr_cmd_ready", cmd_ready, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_val("mr_no_result", res_valid, 0);
        end
        run_cmd(8'h81, 3'd4, 4'd3, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout got=0x0 exp=0x1");
        $fatal(1, "timeout");
    end

endmodule
